// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash reader: SPI register map, control-register
// field positions and the reader FSM encoding.
package spi_flash_reader_pkg;

  localparam logic [1:0] SPI_DATAREG = 2'd0;
  localparam logic [1:0] SPI_IMMDATA = 2'd1;
  localparam logic [1:0] SPI_CTRLREG = 2'd2;

  localparam int CTRL_ENABLE_BIT = 24;
  localparam int CTRL_SSEL_BIT   = 16;
  localparam int CTRL_SLAVE_LSB  = 8;
  localparam int CTRL_SIZE_LSB   = 0;

  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_CMD,
    ST_CMDWAIT,
    ST_RDREQ,
    ST_RDWAIT,
    ST_OUT,
    ST_DESEL,
    ST_DONE
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic       enable,
                                            input logic       ssel,
                                            input logic [1:0] slave,
                                            input logic [1:0] size);
    logic [31:0] w;
    w = '0;
    w[CTRL_ENABLE_BIT]       = enable;
    w[CTRL_SSEL_BIT]         = ssel;
    w[CTRL_SLAVE_LSB +: 2]   = slave;
    w[CTRL_SIZE_LSB +: 2]    = size;
    return w;
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// SPI register-bus master port plus the 32-bit output word stream of the reader.
interface spi_flash_reader_if;
  logic        spi_select;
  logic        spi_rd;
  logic [3:0]  spi_we;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata;
  logic [31:0] spi_rdata;
  logic        spi_wbusy;
  logic        spi_rbusy;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output spi_select, spi_rd, spi_we, spi_addr, spi_wdata, out_valid, out_data,
    input  spi_rdata, spi_wbusy, spi_rbusy, out_ready
  );

  modport slave (
    input  spi_select, spi_rd, spi_we, spi_addr, spi_wdata, out_valid, out_data,
    output spi_rdata, spi_wbusy, spi_rbusy, out_ready
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Reads len 32-bit words from SPI flash via the SPI register bus and streams them out.
// All outputs are registered; each state's bus values are loaded on the transition into it.
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int unsigned SLAVE    = 0,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int unsigned CMD_WAIT = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [23:0]        addr,
  input  logic [15:0]        len,
  output logic               busy,
  output logic               done,
  spi_flash_reader_if.master bus
);

  localparam logic [31:0] CFG_WORD   = ctrl_word(1'b1, 1'b1, SLAVE[1:0], SIZE_WORD);
  localparam logic [31:0] DESEL_WORD = ctrl_word(1'b0, 1'b0, 2'b00, 2'b00);
  localparam logic [15:0] WAIT_LOAD  = (CMD_WAIT > 0) ? 16'(CMD_WAIT - 1) : 16'd0;

  state_t      state;
  logic [23:0] addr_q;
  logic [15:0] remaining;
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.spi_select <= 1'b0;
      bus.spi_rd     <= 1'b0;
      bus.spi_we     <= 4'h0;
      bus.spi_addr   <= 2'd0;
      bus.spi_wdata  <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
    end else begin
      // Bus is idle unless the next state drives it.
      done           <= 1'b0;
      bus.spi_select <= 1'b0;
      bus.spi_rd     <= 1'b0;
      bus.spi_we     <= 4'h0;
      bus.spi_addr   <= 2'd0;
      bus.spi_wdata  <= '0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= addr;
            remaining <= len;
            busy      <= 1'b1;
            if (len == 16'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state          <= ST_CFG;
              bus.spi_select <= 1'b1;
              bus.spi_we     <= 4'hF;
              bus.spi_addr   <= SPI_CTRLREG;
              bus.spi_wdata  <= CFG_WORD;
            end
          end
        end

        ST_CFG: begin
          state          <= ST_CMD;
          bus.spi_select <= 1'b1;
          bus.spi_we     <= 4'hF;
          bus.spi_addr   <= SPI_DATAREG;
          bus.spi_wdata  <= {READ_CMD, addr_q};
        end

        ST_CMD: begin
          if (bus.spi_wbusy) begin
            bus.spi_select <= 1'b1;
            bus.spi_we     <= 4'hF;
            bus.spi_addr   <= SPI_DATAREG;
            bus.spi_wdata  <= {READ_CMD, addr_q};
          end else if (CMD_WAIT == 0) begin
            state          <= ST_RDREQ;
            bus.spi_select <= 1'b1;
            bus.spi_rd     <= 1'b1;
          end else begin
            state    <= ST_CMDWAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end

        ST_CMDWAIT: begin
          if (wait_cnt == 16'd0) begin
            state          <= ST_RDREQ;
            bus.spi_select <= 1'b1;
            bus.spi_rd     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        ST_RDREQ: begin
          state          <= ST_RDWAIT;
          bus.spi_select <= 1'b1;
          bus.spi_rd     <= 1'b1;
        end

        ST_RDWAIT: begin
          if (bus.spi_rbusy) begin
            bus.spi_select <= 1'b1;
            bus.spi_rd     <= 1'b1;
          end else begin
            state         <= ST_OUT;
            bus.out_data  <= bus.spi_rdata;
            bus.out_valid <= 1'b1;
          end
        end

        ST_OUT: begin
          // Next read is only issued once the current word has been taken.
          if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
            remaining      <= remaining - 16'd1;
            bus.spi_select <= 1'b1;
            if (remaining == 16'd1) begin
              state         <= ST_DESEL;
              bus.spi_we    <= 4'b1000;
              bus.spi_addr  <= SPI_CTRLREG;
              bus.spi_wdata <= DESEL_WORD;
            end else begin
              state      <= ST_RDREQ;
              bus.spi_rd <= 1'b1;
            end
          end
        end

        ST_DESEL: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural SPI register-block and flash model.
module tb_spi_flash_reader;
  import spi_flash_reader_pkg::*;

  typedef struct packed {
    logic [1:0]  a;
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] addr;
  logic [15:0] len;
  logic        busy;
  logic        done;

  spi_flash_reader_if bus();

  spi_flash_reader #(.SLAVE(0), .READ_CMD(8'h03), .CMD_WAIT(34)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  flash_mem [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  wr_t         wr_q  [$];
  int          got_rd = 0;

  int          done_cnt = 0, sel_cyc = 0, cmd_cyc = 0, rd_starts = 0, valid_cyc = 0;
  int          wcnt = 0, rcnt = 0;
  bit          ract = 1'b0, prev_rd = 1'b0;
  logic [23:0] maddr = '0;
  logic [31:0] rword = '0;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {flash_mem[b], flash_mem[b + 8'd1], flash_mem[b + 8'd2], flash_mem[b + 8'd3]};
  endfunction

  // SPI block model and bus monitor, evaluated mid-cycle so responses settle before the DUT edge.
  always @(negedge clk) begin
    if (done)                           done_cnt  <= done_cnt + 1;
    if (bus.spi_select)                 sel_cyc   <= sel_cyc + 1;
    if (bus.out_valid)                  valid_cyc <= valid_cyc + 1;
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (bus.spi_select && bus.spi_we != 4'h0 && bus.spi_addr == SPI_DATAREG)
      cmd_cyc <= cmd_cyc + 1;

    if (!reset) begin
      wcnt <= 0; rcnt <= 0; ract <= 1'b0; prev_rd <= 1'b0; maddr <= '0; rword <= '0;
      bus.spi_wbusy <= 1'b0; bus.spi_rbusy <= 1'b0; bus.spi_rdata <= '0;
    end else begin
      prev_rd       <= bus.spi_rd;
      bus.spi_wbusy <= (wcnt != 0);
      if (wcnt != 0) begin
        wcnt <= wcnt - 1;
      end else if (bus.spi_select && bus.spi_we != 4'h0) begin
        wr_q.push_back({bus.spi_addr, bus.spi_we, bus.spi_wdata});
        if (bus.spi_addr == SPI_CTRLREG && bus.spi_we == 4'hF) wcnt <= 2;
        if (bus.spi_addr == SPI_DATAREG) maddr <= bus.spi_wdata[23:0];
      end
      if (bus.spi_rd && !prev_rd) begin
        ract          <= 1'b1;
        rcnt          <= 3;
        bus.spi_rbusy <= 1'b1;
        rword         <= flash_word(maddr);
        maddr         <= maddr + 24'd4;
        rd_starts     <= rd_starts + 1;
      end else if (ract) begin
        if (rcnt == 0) begin
          ract          <= 1'b0;
          bus.spi_rbusy <= 1'b0;
          bus.spi_rdata <= rword;
        end else begin
          rcnt <= rcnt - 1;
        end
      end
    end
  end

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    addr = a; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; addr = '0; len = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, bus.out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: busy/done/valid=%b expected 000", {busy, done, bus.out_valid});
    end
    n_checks++;
    if ({bus.spi_select, bus.spi_rd, bus.spi_we, bus.spi_addr} !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus: sel/rd/we/addr=%h expected 00",
                         {bus.spi_select, bus.spi_rd, bus.spi_we, bus.spi_addr});
    end
    n_checks++;
    if (bus.spi_wdata !== 32'h0 || bus.out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: wdata=%h out_data=%h expected 0", bus.spi_wdata, bus.out_data);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_single();
    int wr0, rd0, dn0, cmd0; bit ok; logic [31:0] e;
    flash_mem[8'h45] = 8'hAA; flash_mem[8'h46] = 8'hBB;
    flash_mem[8'h47] = 8'hCC; flash_mem[8'h48] = 8'hDD;
    exp_q.push_back(32'hAABBCCDD);
    wr0 = wr_q.size(); rd0 = rd_starts; dn0 = done_cnt; cmd0 = cmd_cyc;
    pulse_start(24'h012345, 16'd1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: busy=%b expected 1", busy); end
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: done=0 expected 1 within 400 cycles"); end
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_after: done/busy=%b expected 00", {done, busy});
    end
    n_checks++;
    if (wr_q.size() - wr0 != 3) begin
      n_fail++; $display("FAIL single_nwr: %0d writes expected 3", wr_q.size() - wr0);
    end else begin
      n_checks++;
      if (wr_q[wr0] !== wr_t'{SPI_CTRLREG, 4'hF, 32'h0101_0003}) begin
        n_fail++; $display("FAIL single_cfg: %h expected %h", wr_q[wr0], wr_t'{SPI_CTRLREG, 4'hF, 32'h0101_0003});
      end
      n_checks++;
      if (wr_q[wr0 + 1] !== wr_t'{SPI_DATAREG, 4'hF, 32'h0301_2345}) begin
        n_fail++; $display("FAIL single_cmd: %h expected %h", wr_q[wr0 + 1], wr_t'{SPI_DATAREG, 4'hF, 32'h0301_2345});
      end
      n_checks++;
      if (wr_q[wr0 + 2] !== wr_t'{SPI_CTRLREG, 4'b1000, 32'h0}) begin
        n_fail++; $display("FAIL single_desel: %h expected %h", wr_q[wr0 + 2], wr_t'{SPI_CTRLREG, 4'b1000, 32'h0});
      end
    end
    n_checks++;
    if (cmd_cyc - cmd0 != 3) begin
      n_fail++; $display("FAIL single_cmdhold: cmd cycles=%0d expected 3", cmd_cyc - cmd0);
    end
    n_checks++;
    if (rd_starts - rd0 != 1) begin
      n_fail++; $display("FAIL single_reads: %0d expected 1", rd_starts - rd0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_rd >= got_q.size()) begin
        n_fail++; $display("FAIL single_word: none expected %h", e);
      end else begin
        if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL single_word: %h expected %h", got_q[got_rd], e); end
        got_rd++;
      end
    end
    n_checks++;
    if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL single_done: %0d pulses expected 1", done_cnt - dn0); end
  endtask

  task automatic test_len_zero();
    int sel0, wr0, dn0;
    sel0 = sel_cyc; wr0 = wr_q.size(); dn0 = done_cnt;
    pulse_start(24'h000100, 16'd0);
    n_checks++;
    if ({done, busy} !== 2'b11) begin
      n_fail++; $display("FAIL zero_done: done/busy=%b expected 11", {done, busy});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL zero_after: done/busy=%b expected 00", {done, busy});
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (sel_cyc != sel0 || wr_q.size() != wr0) begin
      n_fail++; $display("FAIL zero_bus: select cycles=%0d writes=%0d expected 0 0", sel_cyc - sel0, wr_q.size() - wr0);
    end
    n_checks++;
    if (done_cnt - dn0 != 1) begin n_fail++; $display("FAIL zero_pulses: %0d expected 1", done_cnt - dn0); end
  endtask

  task automatic test_stall();
    int g0, rd0, dn0; bit ok, stable; logic [31:0] hold, e;
    for (int i = 0; i < 12; i++) flash_mem[8'h80 + 8'(i)] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 3; w++)
      exp_q.push_back({flash_mem[8'h80 + 8'(4*w)], flash_mem[8'h81 + 8'(4*w)],
                       flash_mem[8'h82 + 8'(4*w)], flash_mem[8'h83 + 8'(4*w)]});
    g0 = got_q.size(); rd0 = rd_starts; dn0 = done_cnt;
    bus.out_ready = 1'b1;
    pulse_start(24'h000080, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.out_valid && got_q.size() == g0 + 1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_word2: not presented, expected within 500 cycles"); end
    bus.out_ready = 1'b0;
    hold = bus.out_data; stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.out_data !== hold) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL stall_hold: data=%h valid=%b expected %h 1", bus.out_data, bus.out_valid, hold); end
    n_checks++;
    if (rd_starts - rd0 != 2) begin n_fail++; $display("FAIL stall_reads: %0d reads expected 2", rd_starts - rd0); end
    bus.out_ready = 1'b1;
    wait_done(500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout: done=0 expected 1 within 500 cycles"); end
    @(posedge clk); #1;
    for (int w = 0; w < 3; w++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_rd >= got_q.size()) begin
        n_fail++; $display("FAIL stall_word%0d: none expected %h", w, e);
      end else begin
        if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL stall_word%0d: %h expected %h", w, got_q[got_rd], e); end
        got_rd++;
      end
    end
    n_checks++;
    if (done_cnt - dn0 != 1 || rd_starts - rd0 != 3) begin
      n_fail++; $display("FAIL stall_totals: done=%0d reads=%0d expected 1 3", done_cnt - dn0, rd_starts - rd0);
    end
  endtask

  task automatic test_busy_ignore();
    int wr0, dn0, sel0, v0, g0; bit ok; logic [31:0] e;
    for (int i = 0; i < 8; i++) flash_mem[8'hC0 + 8'(i)] = 8'hC0 + 8'(i * 17);
    exp_q.push_back({8'hC0, 8'hD1, 8'hE2, 8'hF3});
    exp_q.push_back({8'h04, 8'h15, 8'h26, 8'h37});
    wr0 = wr_q.size(); dn0 = done_cnt; v0 = valid_cyc; g0 = got_q.size();
    bus.out_ready = 1'b1;
    pulse_start(24'h0000C0, 16'd2);
    repeat (5) @(posedge clk);
    pulse_start(24'h0000F0, 16'd5);
    wait_done(500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ignore_timeout: done=0 expected 1 within 500 cycles"); end
    @(posedge clk); #1;
    n_checks++;
    if (wr_q.size() - wr0 < 2 || wr_q[wr0 + 1] !== wr_t'{SPI_DATAREG, 4'hF, 32'h0300_00C0}) begin
      n_fail++; $display("FAIL ignore_cmd: writes=%0d cmd=%h expected %h", wr_q.size() - wr0,
                         (wr_q.size() - wr0 >= 2) ? wr_q[wr0 + 1] : wr_t'(0), wr_t'{SPI_DATAREG, 4'hF, 32'h0300_00C0});
    end
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_rd >= got_q.size()) begin
        n_fail++; $display("FAIL ignore_word%0d: none expected %h", w, e);
      end else begin
        if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL ignore_word%0d: %h expected %h", w, got_q[got_rd], e); end
        got_rd++;
      end
    end
    n_checks++;
    if (valid_cyc - v0 != 2 || got_q.size() - g0 != 2) begin
      n_fail++; $display("FAIL ignore_rate: valid cycles=%0d words=%0d expected 2 2", valid_cyc - v0, got_q.size() - g0);
    end
    sel0 = sel_cyc;
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (sel_cyc != sel0 || done_cnt - dn0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_quiet: select cycles=%0d done=%0d busy=%b expected 0 1 0",
                         sel_cyc - sel0, done_cnt - dn0, busy);
    end
  endtask

  task automatic test_reset_midjob();
    int dn0, g0; bit ok; logic [31:0] e;
    for (int i = 0; i < 8; i++) flash_mem[8'h20 + 8'(i)] = 8'h90 + 8'(i);
    dn0 = done_cnt; g0 = got_q.size();
    bus.out_ready = 1'b1;
    pulse_start(24'h000020, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.spi_rd) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!ok || bus.spi_rd !== 1'b1) begin n_fail++; $display("FAIL midrst_reach: rd=%b expected 1 (read wait)", bus.spi_rd); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.out_valid, bus.spi_select, bus.spi_rd} !== 5'b0 || bus.out_data !== 32'h0) begin
      n_fail++; $display("FAIL midrst_ctl: busy/done/valid/sel/rd=%b out_data=%h expected 00000 0",
                         {busy, done, bus.out_valid, bus.spi_select, bus.spi_rd}, bus.out_data);
    end
    n_checks++;
    if ({bus.spi_we, bus.spi_addr} !== 6'h0 || bus.spi_wdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_bus: we/addr=%h wdata=%h expected 0 0", {bus.spi_we, bus.spi_addr}, bus.spi_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != dn0 || got_q.size() != g0) begin
      n_fail++; $display("FAIL midrst_abandon: done=%0d words=%0d expected 0 0", done_cnt - dn0, got_q.size() - g0);
    end
    exp_q.push_back({8'h94, 8'h95, 8'h96, 8'h97});
    pulse_start(24'h000024, 16'd1);
    wait_done(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_timeout: done=0 expected 1 within 400 cycles"); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (got_rd >= got_q.size()) begin
      n_fail++; $display("FAIL midrst_word: none expected %h", e);
    end else begin
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL midrst_word: %h expected %h", got_q[got_rd], e); end
      got_rd++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'(i);
    test_reset();
    test_single();
    test_len_zero();
    test_stall();
    test_busy_ignore();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter SLAVE, default 0: SPI slave-select index (0..3) written into the ctrl register.
REQ-002 Parameter READ_CMD, default 8'h03: flash read opcode.
REQ-003 Parameter CMD_WAIT, default 34: clk cycles to wait after the command write before the first data read.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-007 addr  in  24  flash byte address, captured on start.
REQ-008 len  in  16  32-bit words to read, captured on start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when the job completes.
REQ-011 out_valid / out_ready / out_data  out / in / 32  word stream; transfer when valid&ready.
REQ-012 spi_select, spi_rd  out  1 each; spi_we  out  4; spi_addr  out  2; spi_wdata  out  32  SPI register-bus master.
REQ-013 spi_rdata  in  32; spi_wbusy, spi_rbusy  in  1 each  SPI register-bus responses.

Function
REQ-014 States: IDLE, CFG, CMD, CMDWAIT, RDREQ, RDWAIT, OUT, DESEL, DONE.
REQ-015 IDLE, start=1, len!=0 -> CFG; start=1, len=0 -> DONE with no bus activity; start while busy ignored.
REQ-016 CFG: one cycle, select=1, we=4'hF, addr=2, wdata = bit24=1, bit16=1, bits[9:8]=SLAVE, bits[1:0]=2'b11, others 0 -> CMD.
REQ-017 CMD: select=1, we=4'hF, addr=0, wdata={READ_CMD, addr}; stay while spi_wbusy=1, then -> CMDWAIT.
REQ-018 CMDWAIT: bus idle, count CMD_WAIT cycles -> RDREQ.
REQ-019 RDREQ: one cycle, select=1, rd=1, addr=0 -> RDWAIT.
REQ-020 RDWAIT: hold select=1, rd=1, addr=0; on first cycle with spi_rbusy=0, latch spi_rdata into out_data -> OUT.
REQ-021 OUT: out_valid=1, out_data stable, bus idle; on out_ready, decrement word count; remaining>0 -> RDREQ, else -> DESEL.
REQ-022 DESEL: one cycle, select=1, we=4'b1000, addr=2, wdata bit24=0, all others 0 -> DONE.
REQ-023 DONE: done=1 for one cycle -> IDLE.
REQ-024 Bus outputs (select, rd, we, wdata, addr) are 0 in every state/cycle not listed above.
REQ-025 Flash byte order: first received byte appears in out_data[31:24].
REQ-026 Word counter 16 bits; len=16'hFFFF yields exactly 65535 words, no wrap.
REQ-027 out_ready held high gives one word per read cycle; stalls of any length lose no data.

Reset
REQ-028 reset low: state IDLE; busy, done, out_valid, spi_select, spi_rd = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0; out_data = 0; counters = 0.
REQ-029 Reset mid-job abandons the job with no done pulse; slave-select release is the SPI block's own reset duty.

Structure
REQ-030 Shared package holds SPI register addresses (DATAREG=0, IMMDATA=1, CTRLREG=2), ctrl-register bit positions, size code WORD=2'b11, and this block's state encoding.
REQ-031 Single module; no sub-module.

Verification
REQ-032 start, addr=24'h012345, len=1 -> CFG wdata 32'h0101_0003, CMD wdata 32'h0301_2345, one read, one out word, DESEL write, done pulse.
REQ-033 SPI model returns bytes AA BB CC DD -> out_data 32'hAABBCCDD.
REQ-034 len=3, out_ready low 10 cycles on word 2 -> no new read until accepted; 3 words in order; done once.
REQ-035 len=0 -> done 1 cycle after start; spi_select never asserted.
REQ-036 reset low while in RDWAIT -> all outputs at reset values next edge; no done; new start completes normally.
REQ-037 start pulsed while busy -> ignored; captured addr/len unchanged.
